// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the simple computer.
//
// Receives a framed 8N1 byte stream on RXD and turns each payload byte into
// one write on the external memory-edit port. While a download is in flight
// (and after any failed download) HOLD is asserted so the CPU stays in reset.
//
// Frame: 0xA5, ADDR, LEN, DATA x N, [CSUM]. N = LEN, or 256 when LEN = 0.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   : a trailing CSUM byte is required; (sum of ADDR, LEN, DATA and
//               CSUM) mod 256 must be 0, otherwise ERR is raised.
//   undefined : no CSUM byte, no sum logic; the frame ends on its last data
//               byte.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (minimum 4).
//
// Ports
//   CLK      in   system clock, rising edge
//   AR       in   synchronous active-low reset
//   RXD      in   serial input, idle high, asynchronous to CLK
//   MEM_ADDR out  address of the current memory write
//   MEM_DATA out  byte of the current memory write
//   MEM_EDIT out  one-cycle write strobe
//   HOLD     out  CPU hold request
//   DONE     out  one-cycle pulse on a successfully completed frame
//   ERR      out  sticky error flag, cleared by reset or the next header

module prog_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       AR,
    input  logic       RXD,
    output logic [7:0] MEM_ADDR,
    output logic [7:0] MEM_DATA,
    output logic       MEM_EDIT,
    output logic       HOLD,
    output logic       DONE,
    output logic       ERR
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]     SYNC_BYTE = 8'hA5;

    // ------------------------------------------------------------------
    // Input synchronizer: rxd_p0/rxd_p1 form the 2-flop synchronizer,
    // rxd_p2 is the previous synchronized value used for edge detection.
    // ------------------------------------------------------------------
    logic rxd_p0;
    logic rxd_p1;
    logic rxd_p2;

    always_ff @(posedge CLK) begin
        if (!AR) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= RXD;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } r_state_t;

    r_state_t      r_state;
    r_state_t      r_next;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick_half;
    logic          tick_bit;
    logic          byte_valid;
    logic          frame_err;
    logic [7:0]    rx_byte;

    assign tick_half = (clk_cnt == HALF_LAST);
    assign tick_bit  = (clk_cnt == BIT_LAST);

    always_ff @(posedge CLK) begin
        if (!AR) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (rxd_p2 && !rxd_p1) begin
                    r_next = R_START;
                end
            end
            R_START: begin
                // Line back high at mid start bit means a glitch, not a start.
                if (tick_half) begin
                    r_next = rxd_p1 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (tick_bit && (bit_cnt == 3'd7)) begin
                    r_next = R_STOP;
                end
            end
            R_STOP: begin
                if (tick_bit) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (r_state == R_STOP && tick_bit) begin
            byte_valid = rxd_p1;
            frame_err  = !rxd_p1;
        end
    end

    assign rx_byte = shreg;

    // Bit timing counter restarts on every state change and every data bit,
    // so each sample point is measured from the previous one.
    always_ff @(posedge CLK) begin
        if (!AR) begin
            clk_cnt <= '0;
            bit_cnt <= 3'd0;
        end else begin
            if (r_state == R_IDLE || r_next != r_state ||
                (r_state == R_DATA && tick_bit)) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
            if (r_state == R_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (r_state == R_DATA && tick_bit) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge CLK) begin
        if (r_state == R_DATA && tick_bit) begin
            shreg <= {rxd_p1, shreg[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        F_SYNC,
        F_ADDR,
        F_LEN,
        F_DATA,
        F_CSUM
    } f_state_t;

    f_state_t   f_state;
    f_state_t   f_next;
    logic [7:0] ptr;
    logic [7:0] ptr_n;
    logic [8:0] cnt;
    logic [8:0] cnt_n;
    logic [7:0] addr_n;
    logic [7:0] data_n;
    logic       edit_n;
    logic       done_n;
    logic       hold_n;
    logic       err_n;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_n;
    logic [7:0] csum_total;

    assign csum_total = sum + rx_byte;
`endif

    always_ff @(posedge CLK) begin
        if (!AR) begin
            f_state <= F_SYNC;
        end else begin
            f_state <= f_next;
        end
    end

    always_comb begin
        f_next = f_state;
        if (frame_err) begin
            f_next = F_SYNC;
        end else if (byte_valid) begin
            case (f_state)
                F_SYNC: begin
                    if (rx_byte == SYNC_BYTE) begin
                        f_next = F_ADDR;
                    end
                end
                F_ADDR: f_next = F_LEN;
                F_LEN:  f_next = F_DATA;
                F_DATA: begin
                    if (cnt == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        f_next = F_CSUM;
`else
                        f_next = F_SYNC;
`endif
                    end
                end
                F_CSUM:  f_next = F_SYNC;
                default: f_next = F_SYNC;
            endcase
        end
    end

    always_comb begin
        ptr_n  = ptr;
        cnt_n  = cnt;
        addr_n = MEM_ADDR;
        data_n = MEM_DATA;
        edit_n = 1'b0;
        done_n = 1'b0;
        hold_n = HOLD;
        err_n  = ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_n  = sum;
`endif
        if (frame_err) begin
            // A broken byte between frames is just line noise.
            if (f_state != F_SYNC) begin
                err_n = 1'b1;
            end
        end else if (byte_valid) begin
            case (f_state)
                F_SYNC: begin
                    if (rx_byte == SYNC_BYTE) begin
                        hold_n = 1'b1;
                        err_n  = 1'b0;
                    end
                end
                F_ADDR: begin
                    ptr_n = rx_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_n = rx_byte;
`endif
                end
                F_LEN: begin
                    cnt_n = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_n = sum + rx_byte;
`endif
                end
                F_DATA: begin
                    addr_n = ptr;
                    data_n = rx_byte;
                    edit_n = 1'b1;
                    ptr_n  = ptr + 8'd1;
                    cnt_n  = cnt - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_n  = sum + rx_byte;
`else
                    if (cnt == 9'd1) begin
                        done_n = 1'b1;
                        hold_n = 1'b0;
                    end
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                F_CSUM: begin
                    if (csum_total == 8'd0) begin
                        done_n = 1'b1;
                        hold_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!AR) begin
            MEM_ADDR <= 8'd0;
            MEM_DATA <= 8'd0;
            MEM_EDIT <= 1'b0;
            HOLD     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            MEM_ADDR <= addr_n;
            MEM_DATA <= data_n;
            MEM_EDIT <= edit_n;
            HOLD     <= hold_n;
            DONE     <= done_n;
            ERR      <= err_n;
        end
    end

    // Pointer, count and sum are always loaded before use within a frame.
    always_ff @(posedge CLK) begin
        ptr <= ptr_n;
        cnt <= cnt_n;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum <= sum_n;
`endif
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       AR  = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_DATA;
    logic       MEM_EDIT;
    logic       HOLD;
    logic       DONE;
    logic       ERR;

    prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .CLK      (CLK),
        .AR       (AR),
        .RXD      (RXD),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .MEM_EDIT (MEM_EDIT),
        .HOLD     (HOLD),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    int         done_exp = 0;
    logic       prev_edit = 1'b0;
    logic [7:0] pl[256];

    // Scoreboard monitor: every write/done the DUT presents is matched
    // against what the stimulus predicted.
    always @(negedge CLK) begin
        wr_t e;
        if (MEM_EDIT === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: actual addr=%02h data=%02h, required no write",
                         MEM_ADDR, MEM_DATA);
            end else begin
                e = wq.pop_front();
                if (MEM_ADDR !== e.addr || MEM_DATA !== e.data) begin
                    errors++;
                    $display("FAIL write: actual addr=%02h data=%02h, required addr=%02h data=%02h",
                             MEM_ADDR, MEM_DATA, e.addr, e.data);
                end
            end
            checks++;
            if (prev_edit === 1'b1) begin
                errors++;
                $display("FAIL edit_gap: actual MEM_EDIT high two cycles, required single-cycle");
            end
        end
        if (DONE === 1'b1) begin
            checks++;
            if (done_exp == 0) begin
                errors++;
                $display("FAIL unexpected_done: actual DONE=1, required 0");
            end else begin
                done_exp--;
            end
            checks++;
            if (HOLD !== 1'b0) begin
                errors++;
                $display("FAIL hold_at_done: actual %b, required 0", HOLD);
            end
            checks++;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (MEM_EDIT !== 1'b0) begin
                errors++;
                $display("FAIL done_edit_align: actual MEM_EDIT=%b, required 0", MEM_EDIT);
            end
`else
            if (MEM_EDIT !== 1'b1) begin
                errors++;
                $display("FAIL done_edit_align: actual MEM_EDIT=%b, required 1", MEM_EDIT);
            end
`endif
        end
        prev_edit <= MEM_EDIT;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            idle(CPB);
        end
        RXD = stop;
        idle(CPB);
        RXD = 1'b1;
        idle(2);
    endtask

    // Sends A5, addr, len, pl[0..n-1] and (when enabled) a checksum byte.
    // csum < 0 selects the correct checksum; otherwise the given byte is sent.
    task automatic frame(input logic [7:0] addr, input int n, input int csum);
        logic [7:0] len;
        logic [7:0] total;
        logic [7:0] cbyte;
        bit         ok;
        len   = n[7:0];
        total = addr + len;
        for (int i = 0; i < n; i++) total = total + pl[i];
        cbyte = (csum < 0) ? (8'd0 - total) : csum[7:0];
`ifdef PROG_LOADER_CHECKSUM_EN
        ok = ((total + cbyte) == 8'd0);
`else
        ok = 1'b1;
`endif
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = addr + i[7:0];
            e.data = pl[i];
            wq.push_back(e);
        end
        if (ok) done_exp++;
        send_byte(8'hA5, 1'b1);
        chk("hold_after_header", {31'd0, HOLD}, 32'd1);
        chk("err_after_header", {31'd0, ERR}, 32'd0);
        send_byte(addr, 1'b1);
        send_byte(len, 1'b1);
        for (int i = 0; i < n; i++) send_byte(pl[i], 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(cbyte, 1'b1);
`endif
        idle(4);
        chk("hold_end", {31'd0, HOLD}, ok ? 32'd0 : 32'd1);
        chk("err_end", {31'd0, ERR}, ok ? 32'd0 : 32'd1);
        chk("writes_drained", wq.size(), 32'd0);
        chk("done_count", done_exp, 32'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, {MEM_ADDR, MEM_DATA, 5'd0, MEM_EDIT, HOLD, DONE, 8'd0}
                  | {24'd0, 7'd0, ERR}, 32'd0);
    endtask

    initial begin
        // Reset with RXD toggling
        AR  = 1'b0;
        RXD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            RXD = ~RXD;
            chk_outputs_zero("reset_outputs");
        end
        RXD = 1'b1;
        idle(2);
        AR = 1'b1;
        idle(4);
        chk_outputs_zero("after_reset_idle");

        // Good three-byte frame
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        frame(8'h10, 3, -1);

        // Address wrap with LEN = 0 (256 bytes)
        for (int i = 0; i < 256; i++) pl[i] = 8'h01;
        frame(8'hFE, 256, -1);

        // Wrong checksum byte 00, then a good frame recovers
        pl[0] = 8'hAA;
        frame(8'h10, 1, 0);
        pl[0] = 8'h5C; pl[1] = 8'hC3;
        frame(8'h80, 2, -1);

        // Framing error mid-frame
        pl[0] = 8'h44;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h44, 1'b0);
        idle(2);
        chk("ferr_err", {31'd0, ERR}, 32'd1);
        chk("ferr_hold", {31'd0, HOLD}, 32'd1);
        send_byte(8'h55, 1'b1);   // must be ignored in sync hunt
        idle(2);
        chk("ferr_sticky", {31'd0, ERR}, 32'd1);
        pl[0] = 8'h01; pl[1] = 8'h02;
        frame(8'h20, 2, -1);

        // 8-cycle low glitch on idle line
        RXD = 1'b0;
        idle(8);
        RXD = 1'b1;
        idle(12 * CPB);
        chk("glitch_hold", {31'd0, HOLD}, 32'd0);
        chk("glitch_err", {31'd0, ERR}, 32'd0);
        chk("glitch_addr", {24'd0, MEM_ADDR}, 32'h21);
        pl[0] = 8'h7E;
        frame(8'h00, 1, -1);

        // Reset in the middle of a frame
        begin
            wr_t e;
            e.addr = 8'h40;
            e.data = 8'h11;
            wq.push_back(e);
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        chk("pre_reset_hold", {31'd0, HOLD}, 32'd1);
        AR = 1'b0;
        idle(1);
        chk_outputs_zero("midframe_reset");
        AR = 1'b1;
        idle(2);
        send_byte(8'h22, 1'b1);
        idle(4);
        chk("post_reset_hold", {31'd0, HOLD}, 32'd0);
        chk("post_reset_edit", {31'd0, MEM_EDIT}, 32'd0);

        idle(20);
        chk("final_writes_drained", wq.size(), 32'd0);
        chk("final_done_count", done_exp, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
